// File: rtl/multiboot_reboot_ctrl.sv
// Multiboot reboot controller: after a start-up delay, drives an IPROG command
// sequence into the ICAP so the device reloads from one of NUM_IMAGES flash addresses.
module multiboot_reboot_ctrl #(
   parameter int         NUM_IMAGES  = 4,
   parameter int         ADDR_WIDTH  = 24,
   parameter int         CLK_DIV     = 4,
   parameter int         DELAY_WIDTH = 16,
   parameter logic [7:0] READ_OP     = 8'h03,
   parameter int         AUTO_BOOT   = 0,
   parameter int         AUTO_IMAGE  = 0,
   localparam int        SELW        = $clog2(NUM_IMAGES)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_IMAGES*ADDR_WIDTH-1:0] addr_table,
   input  logic [SELW-1:0]                  sel,
   input  logic                             req,
   output logic                             ready,
   output logic                             busy,
   output logic                             err,
   output logic                             icap_clk,
   output logic                             icap_ce_n,
   output logic                             icap_wr_n,
   output logic [15:0]                      icap_din
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_SEQ  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           phase_q, phase_d;
   logic [DELAY_WIDTH-1:0]  delay_q, delay_d;
   logic [3:0]              idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    auto_q, auto_d;
   logic                    err_q, err_d;
   logic                    ce_n_q, ce_n_d;
   logic                    wr_n_q, wr_n_d;
   logic [15:0]             din_q, din_d;

   logic                    tick;
   logic [31:0]             sel_eff;
   logic                    sel_ok;
   logic [ADDR_WIDTH-1:0]   entry;

   function automatic logic [15:0] seq_word(input logic [3:0] idx, input logic [23:0] a);
      case (idx)
         4'd0:    seq_word = 16'hFFFF;
         4'd1:    seq_word = 16'hAA99;
         4'd2:    seq_word = 16'h5566;
         4'd3:    seq_word = 16'h3261;
         4'd4:    seq_word = a[15:0];
         4'd5:    seq_word = 16'h3281;
         4'd6:    seq_word = {READ_OP, a[23:16]};
         4'd7:    seq_word = 16'h30A1;
         4'd8:    seq_word = 16'h000E;
         4'd9,
         4'd10,
         4'd11,
         4'd12:   seq_word = 16'h2000;
         default: seq_word = 16'hFFFF;
      endcase
   endfunction

   // ICAP expects each byte MSB-first on bit 0
   function automatic logic [15:0] bit_rev(input logic [15:0] w);
      for (int b = 0; b < 2; b++) begin
         for (int j = 0; j < 8; j++) begin
            bit_rev[8*b + j] = w[8*b + 7 - j];
         end
      end
   endfunction

   assign tick      = (phase_q == '0);
   assign phase_d   = (phase_q == PW'(CLK_DIV - 1)) ? '0 : phase_q + 1'b1;
   assign icap_clk  = (phase_q >= PW'(CLK_DIV / 2));
   assign ready     = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_SEQ);
   assign err       = err_q;
   assign icap_ce_n = ce_n_q;
   assign icap_wr_n = wr_n_q;
   assign icap_din  = din_q;

   always_comb begin
      sel_eff = auto_q ? 32'(AUTO_IMAGE) : 32'(sel);
      sel_ok  = (sel_eff < 32'(NUM_IMAGES));
      entry   = '0;
      for (int i = 0; i < NUM_IMAGES; i++) begin
         if (sel_eff == 32'(i)) entry = addr_table[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      auto_d  = auto_q;
      err_d   = err_q;
      ce_n_d  = ce_n_q;
      wr_n_d  = wr_n_q;
      din_d   = din_q;
      if (tick) begin
         err_d  = 1'b0;
         ce_n_d = 1'b1;
         wr_n_d = 1'b1;
         din_d  = 16'hFFFF;
         case (state_q)
            ST_WAIT: begin
               if (delay_q == {DELAY_WIDTH{1'b1}}) state_d = ST_IDLE;
               else                                delay_d = delay_q + 1'b1;
            end
            ST_IDLE: begin
               if (auto_q || req) begin
                  auto_d = 1'b0;
                  if (sel_ok) begin
                     addr_d  = entry;
                     idx_d   = 4'd0;
                     state_d = ST_SEQ;
                     ce_n_d  = 1'b0;
                     wr_n_d  = 1'b0;
                     din_d   = bit_rev(seq_word(4'd0, 24'(entry)));
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ST_SEQ: begin
               if (idx_q == 4'd12) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  ce_n_d = 1'b0;
                  wr_n_d = 1'b0;
                  din_d  = bit_rev(seq_word(idx_q + 4'd1, 24'(addr_q)));
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= '0;
         delay_q <= '0;
         state_q <= ST_WAIT;
         idx_q   <= '0;
         auto_q  <= (AUTO_BOOT != 0);
         err_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         din_q   <= 16'hFFFF;
      end else begin
         phase_q <= phase_d;
         delay_q <= delay_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         auto_q  <= auto_d;
         err_q   <= err_d;
         ce_n_q  <= ce_n_d;
         wr_n_q  <= wr_n_d;
         din_q   <= din_d;
      end
      addr_q <= addr_d;
   end

endmodule
